// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen -- RV32I immediate generator (decode stage)
//
// Pulls the immediate field out of a 32-bit instruction and sign- or
// zero-extends it. The main control decoder picks the format through imm_src;
// the opcode bits are never looked at here.
//
// The combinational result (imm_ext) feeds the single-cycle datapath: the ALU
// B-mux and the branch/jump target adder. A registered copy with a valid flag
// (imm_ext_q / out_valid) is provided for pipelined and debug consumers.
//
// Ports
//   clk          system clock, registered outputs update on the rising edge
//   rst_n        asynchronous active-low reset
//   inst         instruction word
//   imm_src      format select: 000 I, 001 S, 010 B, 011 U, 100 J,
//                101 shamt, 110 CSR uimm, 111 reserved
//   in_valid     qualifies inst/imm_src for the registered path
//   imm_ext      combinational extended immediate
//   imm_ext_q    imm_ext captured on the last edge where in_valid was high
//   out_valid    in_valid delayed by one cycle
//   illegal_src  combinational, high for the reserved imm_src code
// -----------------------------------------------------------------------------
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_src,
    input  logic            in_valid,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] imm_ext_q,
    output logic            out_valid,
    output logic            illegal_src
);

    // Field extraction below is written for RV32 only.
    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("imm_gen: only XLEN = 32 is supported");
        end
    endgenerate

    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_U     = 3'b011;
    localparam logic [2:0] SRC_J     = 3'b100;
    localparam logic [2:0] SRC_SHAMT = 3'b101;
    localparam logic [2:0] SRC_CSR   = 3'b110;

    logic            w_sign;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;

    // Every signed format takes its sign from inst[31].
    assign w_sign = inst[31];

    always_comb begin
        w_imm     = '0;
        w_illegal = 1'b0;
        case (imm_src)
            SRC_I:     w_imm = {{20{w_sign}}, inst[31:20]};
            SRC_S:     w_imm = {{20{w_sign}}, inst[31:25], inst[11:7]};
            SRC_B:     w_imm = {{19{w_sign}}, inst[31], inst[7],
                                inst[30:25], inst[11:8], 1'b0};
            SRC_U:     w_imm = {inst[31:12], 12'b0};
            SRC_J:     w_imm = {{11{w_sign}}, inst[31], inst[19:12],
                                inst[20], inst[30:21], 1'b0};
            SRC_SHAMT: w_imm = {27'b0, inst[24:20]};
            SRC_CSR:   w_imm = {27'b0, inst[19:15]};
            // Reserved code, and any X/Z on imm_src, resolves to zero.
            default: begin
                w_imm     = '0;
                w_illegal = (imm_src == 3'b111);
            end
        endcase
    end

    assign imm_ext     = w_imm;
    assign illegal_src = w_illegal;

    // Registered copy: valid always follows in_valid, data only loads on a
    // valid cycle so consumers can keep reading the last good immediate.
    logic [XLEN-1:0] r_imm_ext_q;
    logic            r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm_ext_q <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_imm_ext_q <= w_imm;
            end
        end
    end

    assign imm_ext_q = r_imm_ext_q;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_imm_gen.sv
// -----------------------------------------------------------------------------
// tb_imm_gen -- self-checking bench for imm_gen
//
// Stimulus issues directed vectors and pushes the expected registered value
// into a scoreboard queue; a monitor pops and compares whenever out_valid is
// seen high. Combinational outputs are checked directly at issue time.
// -----------------------------------------------------------------------------
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [2:0]  imm_src;
    logic        in_valid;
    logic [31:0] imm_ext;
    logic [31:0] imm_ext_q;
    logic        out_valid;
    logic        illegal_src;

    imm_gen #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst        (inst),
        .imm_src     (imm_src),
        .in_valid    (in_valid),
        .imm_ext     (imm_ext),
        .imm_ext_q   (imm_ext_q),
        .out_valid   (out_valid),
        .illegal_src (illegal_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [2:0]  src;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: one line per registered transaction.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out_valid: got imm_ext_q=%08h expected no transaction",
                         imm_ext_q);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                $display("MON %-10s imm_ext_q=%08h exp=%08h", e.name, imm_ext_q, e.exp);
                check({e.name, "_q"}, imm_ext_q, e.exp);
            end
        end
    end

    // Drive a vector, check the combinational outputs, optionally queue it.
    task automatic issue(input vec_t v, input logic valid);
        inst     = v.inst;
        imm_src  = v.src;
        in_valid = valid;
        #1;
        $display("ISS %-10s inst=%08h src=%03b imm_ext=%08h ill=%0b", v.name, v.inst,
                 v.src, imm_ext, illegal_src);
        check({v.name, "_comb"}, imm_ext, v.exp);
        check({v.name, "_ill"}, {31'b0, illegal_src}, {31'b0, v.ill});
        if (valid) begin
            sb_q.push_back('{name: v.name, exp: v.exp});
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        vecs[0] = '{"I",     32'hFFF00293, 3'b000, 32'hffffffff, 1'b0};
        vecs[1] = '{"B",     32'h00000463, 3'b010, 32'h00000008, 1'b0};
        vecs[2] = '{"S",     32'hFE000E23, 3'b001, 32'hfffffffc, 1'b0};
        vecs[3] = '{"U",     32'h123452B7, 3'b011, 32'h12345000, 1'b0};
        vecs[4] = '{"J",     32'hFFDFF06F, 3'b100, 32'hfffffffc, 1'b0};
        vecs[5] = '{"SHAMT", 32'h01F29293, 3'b101, 32'h0000001f, 1'b0};
        vecs[6] = '{"CSR",   32'h000FD073, 3'b110, 32'h0000001f, 1'b0};
        vecs[7] = '{"RSVD",  32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1};

        rst_n    = 1'b1;
        inst     = 32'h0;
        imm_src  = 3'b000;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_q",     imm_ext_q, 32'h0);
        check("reset_valid", {31'b0, out_valid}, 32'h0);

        // Release reset away from the clock edge.
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Back-to-back valid vectors across every format.
        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1);
            next_cycle();
        end

        // Hold: load I, then drop in_valid and change inst.
        issue(vecs[0], 1'b1);
        next_cycle();
        issue(vecs[3], 1'b0);
        next_cycle();
        check("hold_valid", {31'b0, out_valid}, 32'h0);
        check("hold_q",     imm_ext_q, 32'hffffffff);

        // Reset mid-stream: in-flight CSR value must be dropped.
        issue(vecs[6], 1'b0);
        in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_q",     imm_ext_q, 32'h0);
        check("rst_async_valid", {31'b0, out_valid}, 32'h0);
        check("rst_live_comb",   imm_ext, 32'h0000001f);
        inst    = 32'hFFF00293;
        imm_src = 3'b000;
        #1;
        check("rst_track_comb",  imm_ext, 32'hffffffff);
        next_cycle();
        check("rst_held_valid",  {31'b0, out_valid}, 32'h0);
        check("rst_held_q",      imm_ext_q, 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        next_cycle();
        check("post_rst_valid",  {31'b0, out_valid}, 32'h0);
        check("post_rst_q",      imm_ext_q, 32'h0);

        // Recovery after reset.
        issue(vecs[4], 1'b1);
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        next_cycle();

        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
